// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access sequencer.
// Contents:
//   state_t     - sequencer states (idle, waiting on memory, done pulse)
//   BE_*        - the legal byte-enable patterns from the byte-enable stage
//   be_legal()  - true when a byte-enable pattern is one the sequencer serves
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
            default:                                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: picks the byte/half selected by the byte enables out of
// the memory word, right-aligns it and sign- or zero-extends it to 32 bits.
// Ports:
//   mem_rdata - raw word from data memory
//   be        - byte enables of the access (one of the legal patterns)
//   sign_ext  - 1 = sign-extend the selected field, 0 = zero-extend
//   result    - aligned, extended load value (word loads pass through)
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [3:0]  be,
    input  logic        sign_ext,
    output logic [31:0] result
);

    always_comb begin
        result = mem_rdata;
        case (be)
            BE_B0: result = {{24{sign_ext & mem_rdata[7]}},  mem_rdata[7:0]};
            BE_B1: result = {{24{sign_ext & mem_rdata[15]}}, mem_rdata[15:8]};
            BE_B2: result = {{24{sign_ext & mem_rdata[23]}}, mem_rdata[23:16]};
            BE_B3: result = {{24{sign_ext & mem_rdata[31]}}, mem_rdata[31:24]};
            BE_H0: result = {{16{sign_ext & mem_rdata[15]}}, mem_rdata[15:0]};
            BE_H1: result = {{16{sign_ext & mem_rdata[31]}}, mem_rdata[31:16]};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle data-memory access sequencer. Latches one access request, drives
// the word-wide memory over a req/ack handshake (with a bounded wait), steers
// store data onto byte lanes and returns a registered, extended load result
// alongside a one-cycle done pulse.
// Ports:
//   clk, rst          - clock (rising edge), asynchronous active-high reset
//   start             - access request, honoured only while idle
//   we, be, addr      - store flag, byte enables, byte address of the access
//   wdata             - unshifted store data
//   mem_read_signed   - sign-extend (1) or zero-extend (0) loads
//   busy, done, err   - sequencer status; err is valid with done
//   rdata             - last completed load result
//   mem_req .. mem_wdata - memory request side; mem_we qualified by mem_req
//   mem_ack, mem_rdata   - memory completion and read word (same cycle)
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic              mem_read_signed,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    // Counter only has to reach TIMEOUT-1: the final no-ack cycle aborts.
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               we_q;
    logic [3:0]         be_q;
    logic [ADDR_W-3:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               sign_q;
    logic [31:0]        rdata_q;
    logic               latch;
    logic               capture;
    logic [31:0]        wdata_steered;
    logic [31:0]        load_word;

    // Low address bits are informational; the byte enables select lanes.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

    // Store steering: replicate the byte/half so whichever lane is enabled sees it.
    always_comb begin
        wdata_steered = wdata;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: wdata_steered = {4{wdata[7:0]}};
            BE_H0, BE_H1:               wdata_steered = {2{wdata[15:0]}};
            default:                    wdata_steered = wdata;
        endcase
    end

    load_align u_load_align (
        .mem_rdata (mem_rdata),
        .be        (be_q),
        .sign_ext  (sign_q),
        .result    (load_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        latch   = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    latch = 1'b1;
                    cnt_d = '0;
                    if (be_legal(be)) begin
                        state_d = StWait;
                        err_d   = 1'b0;
                    end else begin
                        // Illegal pattern: report straight away, never touch memory.
                        state_d = StDone;
                        err_d   = 1'b1;
                    end
                end
            end
            StWait: begin
                if (mem_ack) begin
                    // Ack beats a coincident timeout.
                    state_d = StDone;
                    err_d   = 1'b0;
                    capture = ~we_q;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sign_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (latch) begin
                we_q    <= we;
                be_q    <= be;
                addr_q  <= addr[ADDR_W-1:2];
                wdata_q <= wdata_steered;
                sign_q  <= mem_read_signed;
            end
            if (capture) begin
                rdata_q <= load_word;
            end
        end
    end

    // Status and request strobes decode straight from state so that an
    // asynchronous reset drops them without waiting for a clock edge.
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign err       = done & err_q;
    assign mem_req   = (state_q == StWait);
    assign mem_we    = mem_req & we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a table of directed accesses with expected
// results, hand-written reset/illegal sequences, and random accesses checked
// against an arithmetic reference model.
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              we;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              mem_read_signed;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rdata;

    mem_access_ctrl #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .we              (we),
        .be              (be),
        .addr            (addr),
        .wdata           (wdata),
        .mem_read_signed (mem_read_signed),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .rdata           (rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_be          (mem_be),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [3:0]  b;
        logic [11:0] a;
        logic [31:0] wd;
        logic        s;
        logic [31:0] mrd;
        int          dly;
        logic [31:0] x_wdata;
        logic [31:0] x_rdata;
        logic        x_err;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model, written from the access rules rather than the RTL.
    function automatic bit ref_legal(input logic [3:0] b);
        logic [3:0] ok [7];
        ok = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        foreach (ok[i]) if (ok[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_store(input logic [3:0] b, input logic [31:0] wd);
        int n = $countones(b);
        if (n == 1) return 32'(wd[7:0]) * 32'h0101_0101;
        if (n == 2) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] b, input logic [31:0] d,
                                             input logic s);
        int lo = 0;
        int width;
        logic [31:0] v;
        logic [31:0] mask;
        width = 8 * $countones(b);
        if (width == 32) return d;
        while (lo < 3 && !b[lo]) lo++;
        mask = (32'h1 << width) - 32'h1;
        v = (d >> (8 * lo)) & mask;
        if (s && v[width-1]) v = v | ~mask;
        return v;
    endfunction

    // One complete access. dly = wait cycles before ack; dly >= TIMEOUT means never.
    task automatic do_access(input vec_t v, input string tag);
        bit legal;
        bit acked;
        legal = ref_legal(v.b);
        acked = 1'b0;
        start = 1'b1;
        we = v.w;
        be = v.b;
        addr = v.a;
        wdata = v.wd;
        mem_read_signed = v.s;
        tick();
        if (legal) begin
            for (int j = 0; j < int'(TIMEOUT); j++) begin
                chk({tag, " mem_req"}, 32'(mem_req), 32'h1);
                chk({tag, " done_early"}, 32'(done), 32'h0);
                chk({tag, " mem_we"}, 32'(mem_we), 32'(v.w));
                chk({tag, " mem_be"}, 32'(mem_be), 32'(v.b));
                chk({tag, " mem_addr"}, 32'(mem_addr), 32'(v.a[11:2]));
                if (v.w) chk({tag, " mem_wdata"}, mem_wdata, v.x_wdata);
                // Requests arriving while busy must be ignored.
                start = 1'($urandom_range(0, 1));
                we = 1'($urandom);
                be = 4'($urandom);
                addr = 12'($urandom);
                wdata = $urandom;
                if (j == v.dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.mrd;
                    acked = 1'b1;
                end else begin
                    mem_rdata = $urandom;
                end
                tick();
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                if (acked) break;
            end
        end else begin
            chk({tag, " no_req"}, 32'(mem_req), 32'h0);
            start = 1'b1;
            be = 4'b1111;
        end
        chk({tag, " done"}, 32'(done), 32'h1);
        chk({tag, " err"}, 32'(err), 32'(v.x_err));
        chk({tag, " req_in_done"}, 32'(mem_req), 32'h0);
        chk({tag, " rdata"}, rdata, v.x_rdata);
        tick();
        start = 1'b0;
        chk({tag, " done_pulse"}, 32'(done), 32'h0);
        chk({tag, " idle"}, 32'(busy), 32'h0);
        chk({tag, " idle_req"}, 32'(mem_req), 32'h0);
    endtask

    vec_t tab[$];

    initial begin
        vec_t v;
        rst = 1'b1;
        start = 1'b0;
        we = 1'b0;
        be = 4'b0;
        addr = '0;
        wdata = '0;
        mem_read_signed = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        exp_rdata = '0;

        tick();
        tick();
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst err", 32'(err), 32'h0);
        chk("rst mem_req", 32'(mem_req), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst mem_be", 32'(mem_be), 32'h0);
        chk("rst mem_addr", 32'(mem_addr), 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();

        //        w     be       addr     wdata         s     mem_rdata     dly x_wdata       x_rdata       x_err
        tab.push_back('{1'b0, 4'b0100, 12'h000, 32'h0,        1'b1, 32'h1280_3456, 2,  32'h0,        32'hFFFF_FF80, 1'b0});
        tab.push_back('{1'b0, 4'b1100, 12'h010, 32'h0,        1'b0, 32'h8001_7FFF, 0,  32'h0,        32'h0000_8001, 1'b0});
        tab.push_back('{1'b1, 4'b0010, 12'h105, 32'h0000_00AB, 1'b0, 32'h0,        3,  32'hABAB_ABAB, 32'h0000_8001, 1'b0});
        tab.push_back('{1'b0, 4'b1111, 12'h200, 32'h0,        1'b0, 32'h0,         99, 32'h0,        32'h0000_8001, 1'b1});
        tab.push_back('{1'b0, 4'b1111, 12'h204, 32'h0,        1'b1, 32'hDEAD_BEEF, 14, 32'h0,        32'hDEAD_BEEF, 1'b0});
        tab.push_back('{1'b0, 4'b0011, 12'h008, 32'h0,        1'b1, 32'h1234_8001, 1,  32'h0,        32'hFFFF_8001, 1'b0});
        tab.push_back('{1'b1, 4'b1100, 12'h00E, 32'h0000_BEEF, 1'b0, 32'h0,        0,  32'hBEEF_BEEF, 32'hFFFF_8001, 1'b0});
        tab.push_back('{1'b1, 4'b1111, 12'hFFC, 32'h1234_5678, 1'b0, 32'h0,        5,  32'h1234_5678, 32'hFFFF_8001, 1'b0});
        tab.push_back('{1'b0, 4'b0001, 12'h003, 32'h0,        1'b0, 32'h0000_00FF, 0,  32'h0,        32'h0000_00FF, 1'b0});
        tab.push_back('{1'b0, 4'b1000, 12'h00B, 32'h0,        1'b1, 32'h7F00_0000, 4,  32'h0,        32'h0000_007F, 1'b0});
        tab.push_back('{1'b0, 4'b0110, 12'h050, 32'h0,        1'b0, 32'h0,         0,  32'h0,        32'h0000_007F, 1'b1});
        tab.push_back('{1'b1, 4'b0000, 12'h054, 32'h1111_1111, 1'b0, 32'h0,        0,  32'h0,        32'h0000_007F, 1'b1});

        foreach (tab[i]) do_access(tab[i], $sformatf("vec%0d", i));

        // Reset during WAIT: request drops at once, no done, fresh load works.
        start = 1'b1;
        we = 1'b0;
        be = 4'b0001;
        addr = 12'h040;
        mem_read_signed = 1'b0;
        tick();
        start = 1'b0;
        chk("midrst req_before", 32'(mem_req), 32'h1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst mem_req", 32'(mem_req), 32'h0);
        chk("midrst busy", 32'(busy), 32'h0);
        chk("midrst done", 32'(done), 32'h0);
        tick();
        chk("midrst no_done", 32'(done), 32'h0);
        chk("midrst rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();
        chk("midrst still_idle", 32'(busy), 32'h0);
        v = '{1'b0, 4'b0010, 12'h044, 32'h0, 1'b1, 32'h0000_9A00, 1, 32'h0, 32'hFFFF_FF9A, 1'b0};
        do_access(v, "post_rst");
        exp_rdata = 32'hFFFF_FF9A;

        // Random accesses against the model.
        for (int n = 0; n < 40; n++) begin
            logic [3:0] pick [9];
            pick = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111,
                     4'b0101, 4'b1110};
            v.w = 1'($urandom);
            v.b = pick[$urandom_range(0, 8)];
            v.a = 12'($urandom);
            v.wd = $urandom;
            v.s = 1'($urandom);
            v.mrd = $urandom;
            v.dly = $urandom_range(0, 17);
            v.x_wdata = ref_store(v.b, v.wd);
            if (!ref_legal(v.b)) begin
                v.x_err = 1'b1;
            end else if (v.dly >= int'(TIMEOUT)) begin
                v.x_err = 1'b1;
            end else begin
                v.x_err = 1'b0;
                if (!v.w) exp_rdata = ref_load(v.b, v.mrd, v.s);
            end
            v.x_rdata = exp_rdata;
            do_access(v, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
